// File: rtl/of_hazard_scoreboard.sv
// Operand-fetch interlock: per-register outstanding-write counters, RAW/WAW stall and issue control.
// Build option: define OF_HAZARD_WB_BYPASS_EN to treat a same-cycle final writeback as forwarded.
module of_hazard_scoreboard #(
    parameter int NREGS       = 16,
    parameter int AW          = 4,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   of_valid,
    input  logic [AW-1:0]          read_port1,
    input  logic [AW-1:0]          read_port2,
    input  logic                   use_rs1,
    input  logic                   use_rs2,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_reg,
    input  logic                   ex_ready,
    input  logic                   wb_valid,
    input  logic [AW-1:0]          wb_reg,
    input  logic                   flush,
    output logic                   stall,
    output logic                   issue,
    output logic [NREGS-1:0]       busy,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]       r_cnt [NREGS];
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic                   r_wb_err;

    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_dec;
    logic             w_hz1;
    logic             w_hz2;
    logic             w_raw;
    logic             w_waw_full;
    logic             w_stall;
    logic             w_issue;
    logic             w_wb_zero;

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_reg
            assign w_busy[g] = (r_cnt[g] != '0);
            assign w_inc[g]  = w_issue & wr_en & (wr_reg == AW'(g));
            assign w_dec[g]  = wb_valid & (wb_reg == AW'(g)) & w_busy[g];
        end
    endgenerate

`ifdef OF_HAZARD_WB_BYPASS_EN
    // A writeback retiring the last pending write is forwarded, so it is not a hazard.
    logic w_fwd1;
    logic w_fwd2;
    assign w_fwd1 = wb_valid & (wb_reg == read_port1) & (r_cnt[read_port1] == CNT_W'(1));
    assign w_fwd2 = wb_valid & (wb_reg == read_port2) & (r_cnt[read_port2] == CNT_W'(1));
    assign w_hz1  = use_rs1 & w_busy[read_port1] & ~w_fwd1;
    assign w_hz2  = use_rs2 & w_busy[read_port2] & ~w_fwd2;
`else
    assign w_hz1  = use_rs1 & w_busy[read_port1];
    assign w_hz2  = use_rs2 & w_busy[read_port2];
`endif

    assign w_raw      = w_hz1 | w_hz2;
    assign w_waw_full = wr_en & (r_cnt[wr_reg] == CNT_MAX);
    assign w_stall    = of_valid & (w_raw | w_waw_full);
    // Gating with rst keeps issue low while the counters are held in reset.
    assign w_issue    = of_valid & ~w_stall & ex_ready & ~flush & rst;
    assign w_wb_zero  = wb_valid & ~w_busy[wb_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= r_cnt[i] + CNT_W'(w_inc[i]) - CNT_W'(w_dec[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_wb_err       <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
            // Flush outranks writeback, so a stray writeback during flush is ignored.
            if (w_wb_zero && !flush)
                r_wb_err <= 1'b1;
        end
    end

    assign stall        = w_stall;
    assign issue        = w_issue;
    assign busy         = w_busy;
    assign stall_cycles = r_stall_cycles;
    assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_of_hazard_scoreboard.sv
// Scoreboard bench for of_hazard_scoreboard: directed vectors push expected outputs, a monitor compares.
module tb_of_hazard_scoreboard;

`ifdef OF_HAZARD_WB_BYPASS_EN
    localparam int BP = 1;
`else
    localparam int BP = 0;
`endif
    localparam int S = 3 - BP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        of_valid = 1'b0;
    logic [3:0]  read_port1 = '0;
    logic [3:0]  read_port2 = '0;
    logic        use_rs1 = 1'b0;
    logic        use_rs2 = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_reg = '0;
    logic        ex_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        issue;
    logic [15:0] busy;
    logic [15:0] stall_cycles;
    logic        wb_err;

    of_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .of_valid(of_valid),
        .read_port1(read_port1), .read_port2(read_port2),
        .use_rs1(use_rs1), .use_rs2(use_rs2),
        .wr_en(wr_en), .wr_reg(wr_reg), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
        .stall(stall), .issue(issue), .busy(busy),
        .stall_cycles(stall_cycles), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        stall;
        logic        issue;
        logic [15:0] busy;
        logic [15:0] sc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, id, act, req);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",        e.id, 32'(stall),        32'(e.stall));
                chk("issue",        e.id, 32'(issue),        32'(e.issue));
                chk("busy",         e.id, 32'(busy),         32'(e.busy));
                chk("stall_cycles", e.id, 32'(stall_cycles), 32'(e.sc));
                chk("wb_err",       e.id, 32'(wb_err),       32'(e.err));
            end
        end
    end

    task automatic step(
        input logic rs, input logic ov,
        input logic u1, input logic [3:0] r1, input logic u2, input logic [3:0] r2,
        input logic we, input logic [3:0] wr, input logic exr,
        input logic wbv, input logic [3:0] wbr, input logic fl,
        input logic es, input logic ei, input logic [15:0] eb, input int esc, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rs; of_valid = ov;
        use_rs1 = u1; read_port1 = r1; use_rs2 = u2; read_port2 = r2;
        wr_en = we; wr_reg = wr; ex_ready = exr;
        wb_valid = wbv; wb_reg = wbr; flush = fl;
        e.id = step_id; e.stall = es; e.issue = ei; e.busy = eb; e.sc = 16'(esc); e.err = ee;
        exp_q.push_back(e);
        step_id++;
    endtask

    initial begin
        //    rs ov u1 r1 u2 r2 we wr exr wbv wbr fl | stall issue busy      sc     err
        step(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 0, 16'h0000, 0,     0); // 0 reset
        step(1, 1, 1, 3, 0, 0, 1, 5, 1,  0,  0, 0,   0, 1, 16'h0000, 0,     0); // 1 write r5
        step(1, 1, 0, 0, 1, 5, 0, 0, 1,  0,  0, 0,   1, 0, 16'h0020, 0,     0); // 2 RAW on r5
        step(1, 1, 0, 0, 1, 5, 0, 0, 1,  0,  0, 0,   1, 0, 16'h0020, 1,     0);
        step(1, 1, 0, 0, 1, 5, 0, 0, 1,  1,  5, 0,   1'(1-BP), 1'(BP), 16'h0020, 2, 0); // 4 wb r5
        step(1, 1, 0, 0, 1, 5, 0, 0, 1,  0,  0, 0,   0, 1, 16'h0000, S,     0);
        step(1, 1, 0, 0, 0, 0, 1, 7, 1,  0,  0, 0,   0, 1, 16'h0000, S,     0); // 6 r7 #1
        step(1, 1, 0, 0, 0, 0, 1, 7, 1,  0,  0, 0,   0, 1, 16'h0080, S,     0); // r7 #2
        step(1, 1, 0, 0, 0, 0, 1, 7, 1,  0,  0, 0,   0, 1, 16'h0080, S,     0); // r7 #3
        step(1, 1, 0, 0, 0, 0, 1, 7, 1,  0,  0, 0,   1, 0, 16'h0080, S,     0); // 9 waw_full
        step(1, 1, 0, 0, 0, 0, 1, 7, 1,  1,  7, 0,   1, 0, 16'h0080, S+1,   0); // wb r7
        step(1, 1, 0, 0, 0, 0, 1, 7, 1,  0,  0, 0,   0, 1, 16'h0080, S+2,   0); // 11 fourth issues
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 0, 16'h0080, S+2,   0);
        step(1, 1, 0, 0, 0, 0, 1, 7, 1,  0,  0, 0,   1, 0, 16'h0080, S+2,   0); // 13 cnt7 back at 3
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  1,  7, 0,   0, 0, 16'h0080, S+3,   0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  1,  7, 0,   0, 0, 16'h0080, S+3,   0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  1,  7, 0,   0, 0, 16'h0080, S+3,   0);
        step(1, 1, 0, 0, 0, 0, 1, 2, 0,  0,  0, 0,   0, 0, 16'h0000, S+3,   0); // 17 ex not ready
        step(1, 1, 0, 0, 0, 0, 1, 2, 1,  0,  0, 0,   0, 1, 16'h0000, S+3,   0); // r2 cnt 1
        step(1, 1, 0, 0, 0, 0, 1, 2, 1,  1,  2, 0,   0, 1, 16'h0004, S+3,   0); // 19 inc+dec r2
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 0, 16'h0004, S+3,   0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  1,  2, 0,   0, 0, 16'h0004, S+3,   0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 0, 16'h0000, S+3,   0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  1,  9, 0,   0, 0, 16'h0000, S+3,   0); // 23 wb on idle r9
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 0, 16'h0000, S+3,   1);
        step(1, 1, 0, 0, 0, 0, 1, 1, 1,  0,  0, 0,   0, 1, 16'h0000, S+3,   1); // r1 pending
        step(1, 1, 0, 0, 0, 0, 1, 4, 1,  0,  0, 0,   0, 1, 16'h0002, S+3,   1); // r4 pending
        step(1, 1, 0, 0, 0, 0, 1, 6, 1,  0,  0, 1,   0, 0, 16'h0012, S+3,   1); // 27 flush
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 0, 16'h0000, S+3,   1);
        step(1, 1, 1, 6, 0, 0, 1, 6, 1,  0,  0, 0,   0, 1, 16'h0000, S+3,   1); // 29 self-dep, idle
        step(1, 1, 1, 6, 0, 0, 1, 6, 1,  0,  0, 0,   1, 0, 16'h0040, S+3,   1); // self-dep, busy
        step(0, 1, 1, 6, 0, 0, 1, 6, 1,  0,  0, 0,   0, 0, 16'h0000, 0,     0); // 31 reset mid-stall
        step(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,   0, 0, 16'h0000, 0,     0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/of_hazard_scoreboard.md
Name: of_hazard_scoreboard

Overview:
- Interlock controller for the operand-fetch (OF) stage of the pipelined processor.
- Keeps a per-register count of outstanding (issued, not yet written back) writes.
- Stalls OF while either source register (read_port1/read_port2) has a pending write, or while the destination counter is saturated.
- Issues the instruction to EX when it is hazard-free and EX is ready; decrements counts on writeback, clears them on flush.

Parameters:
- NREGS, 16, number of architectural registers tracked.
- AW, 4, register-address width; must satisfy 2^AW = NREGS.
- CNT_W, 2, width of each outstanding-write counter; max pending writes per register = 2^CNT_W-1.
- STALL_CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- of_valid  in  1  OF holds a decoded instruction.
- read_port1  in  AW  source register 1 of OF instruction.
- read_port2  in  AW  source register 2 of OF instruction.
- use_rs1  in  1  instruction reads read_port1.
- use_rs2  in  1  instruction reads read_port2.
- wr_en  in  1  instruction writes a register.
- wr_reg  in  AW  destination register.
- ex_ready  in  1  EX stage can accept an instruction this cycle.
- wb_valid  in  1  writeback retiring a register write this cycle.
- wb_reg  in  AW  register being written back.
- flush  in  1  pipeline flush; all in-flight writes cancelled.
- stall  out  1  OF must hold its instruction.
- issue  out  1  instruction handed to EX this cycle.
- busy  out  NREGS  bit i = register i has a pending write.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall=1.
- wb_err  out  1  sticky: writeback arrived for a register with count 0.

Behaviour:
- Reset (rst=0, async): all counters 0, busy=0, stall_cycles=0, wb_err=0. Therefore stall=0 and issue=0.
- Hazards:
  - raw = (use_rs1 & busy[read_port1]) | (use_rs2 & busy[read_port2]).
  - waw_full = wr_en & (cnt[wr_reg] == 2^CNT_W-1).
- stall = of_valid & (raw | waw_full). Combinational, same cycle as inputs.
- issue = of_valid & ~stall & ex_ready & ~flush. A cycle with of_valid & ~stall & ~ex_ready is neither stall nor issue; OF holds.
- busy[i] = (cnt[i] != 0). Registered via counters; no combinational path from wb inputs.
- Counter update per register i, each clock:
  - +1 if issue & wr_en & wr_reg==i.
  - -1 if wb_valid & wb_reg==i & cnt[i]!=0.
  - Both in the same cycle on the same register: net 0.
  - wb_valid to a register with cnt 0: counter unchanged, wb_err set to 1. wb_err stays set until reset.
- Flush has priority over issue and wb: all counters cleared next edge; wb_err unchanged.
- stall_cycles: +1 each cycle stall=1; saturates at all-ones.
- Latency: a writeback observed at edge N clears busy after edge N, so a dependent instruction issues at earliest in cycle N+1. No same-cycle bypass unless the optional feature is enabled.
- Self-dependence (read_port == wr_reg) stalls only if that register is already busy.

Optional Feature:
- Macro: OF_HAZARD_WB_BYPASS_EN.
- Defined: a source operand is not a hazard when, in the same cycle, wb_valid & wb_reg==read_portX & cnt[read_portX]==1. The writeback is forwarded; stall drops one cycle earlier.
- Undefined: raw uses busy only, as specified above.

Test Plan:
- Reset release, of_valid=1, use_rs1=1, read_port1=3, wr_en=1, wr_reg=5, ex_ready=1 -> issue=1 in that cycle; next cycle busy=16'h0020.
- Next instruction reads read_port2=5 (use_rs2=1) -> stall=1 and stall_cycles increments each cycle; wb_valid, wb_reg=5 -> busy[5]=0 next cycle, issue=1 the following cycle (one cycle earlier with OF_HAZARD_WB_BYPASS_EN).
- Issue three writes to r7 with no writeback, then a fourth wr_reg=7 -> fourth stalls (waw_full); one wb to r7 -> fourth issues, cnt[7] back to 3.
- Same cycle: issue with wr_reg=2 plus wb_valid wb_reg=2, cnt[2]=1 -> cnt[2] stays 1, busy[2]=1.
- wb_valid wb_reg=9 with cnt[9]=0 -> wb_err=1, stays 1 through later traffic until rst=0.
- Pending writes on r1, r4, flush=1 with of_valid=1, ex_ready=1 -> issue=0, busy=0 next cycle; rst asserted mid-stall -> stall_cycles=0 immediately.
